// File: rtl/sram_adapter_pkg.sv
// sram_adapter_pkg: widths and bundles shared by the port-0 adapter.
// SRAM_ADAPTER_WR_ACK_EN adds an is_wr flag to the response bundle.
package sram_adapter_pkg;

  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WMASKS = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  we;
    logic [NUM_WMASKS-1:0] be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } sram_req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
`ifdef SRAM_ADAPTER_WR_ACK_EN
    logic                  is_wr;
`endif
  } sram_rsp_t;

  localparam int RSP_WIDTH = $bits(sram_rsp_t);

endpackage

// File: rtl/sram_port0_req_adapter_if.sv
// sram_port0_req_adapter_if: request/response streams plus macro pins.
// SRAM_ADAPTER_WR_ACK_EN adds rsp_is_wr.
interface sram_port0_req_adapter_if;
  import sram_adapter_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [NUM_WMASKS-1:0] req_be;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
`ifdef SRAM_ADAPTER_WR_ACK_EN
  logic                  rsp_is_wr;
`endif
  logic                  mem_csb;
  logic                  mem_web;
  logic [NUM_WMASKS-1:0] mem_wmask;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport master (
    output req_valid, req_we, req_be,
    output req_addr, req_wdata,
    output rsp_ready, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata,
`ifdef SRAM_ADAPTER_WR_ACK_EN
    input  rsp_is_wr,
`endif
    input  mem_csb, mem_web, mem_wmask,
    input  mem_addr, mem_din
  );

  modport slave (
    input  req_valid, req_we, req_be,
    input  req_addr, req_wdata,
    input  rsp_ready, mem_dout,
    output req_ready, rsp_valid, rsp_rdata,
`ifdef SRAM_ADAPTER_WR_ACK_EN
    output rsp_is_wr,
`endif
    output mem_csb, mem_web, mem_wmask,
    output mem_addr, mem_din
  );

endinterface

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: small response FIFO, any depth >= 2.
// Pointers wrap modulo DEPTH; push and pop may share an edge.
module sram_rsp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // entry storage, cleared so the head reads 0 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && full));

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(pop && empty));

endmodule

// File: rtl/sram_port0_req_adapter.sv
// sram_port0_req_adapter: req stream to SRAM port-0 pins, credited rsp FIFO.
// SRAM_ADAPTER_WR_ACK_EN makes writes return an ack response.
module sram_port0_req_adapter
  import sram_adapter_pkg::*;
#(
  parameter int RSP_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sram_port0_req_adapter_if.slave  bus
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(RSP_DEPTH);

  sram_req_t   req;
  sram_rsp_t   rsp_in;
  sram_rsp_t   rsp_out;
  logic        rdy_q;
  logic        pend_q;
  logic        fire;
  logic        pop;
  logic        empty;
  logic [CW-1:0] count;
  logic [CW:0]   used;

  assign req = '{we:    bus.req_we,
                 be:    bus.req_be,
                 addr:  bus.req_addr,
                 wdata: bus.req_wdata};

  // credits held by queued entries plus the one in flight
  assign used = {1'b0, count} + {{CW{1'b0}}, pend_q};

  assign bus.req_ready = rdy_q && (used < DEPTH_C);
  assign fire          = bus.req_valid && bus.req_ready;

  assign bus.mem_csb   = !fire;
  assign bus.mem_web   = !(fire && req.we);
  assign bus.mem_wmask = (fire && req.we) ? req.be : '0;
  assign bus.mem_addr  = req.addr;
  assign bus.mem_din   = req.wdata;

  // ready opens on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

`ifdef SRAM_ADAPTER_WR_ACK_EN
  logic pend_wr_q;

  assign rsp_in.rdata = pend_wr_q ? '0 : bus.mem_dout;
  assign rsp_in.is_wr = pend_wr_q;
  assign bus.rsp_is_wr = rsp_out.is_wr;

  // every fire owes one response next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      pend_wr_q <= 1'b0;
    end else begin
      pend_q    <= fire;
      pend_wr_q <= fire && req.we;
    end
  end
`else
  assign rsp_in.rdata = bus.mem_dout;

  // only reads owe a response next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= fire && !req.we;
  end
`endif

  assign bus.rsp_valid = !empty;
  assign bus.rsp_rdata = rsp_out.rdata;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RSP_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend_q),
    .push_data (rsp_in),
    .pop       (pop),
    .pop_data  (rsp_out),
    .count     (count),
    .empty     (empty)
  );

endmodule

// File: tb/tb_sram_port0_req_adapter.sv
// tb_sram_port0_req_adapter: directed bench with a behavioural SRAM macro.
// Covers SRAM_ADAPTER_WR_ACK_EN builds as well as the default build.
module tb_sram_port0_req_adapter;
  import sram_adapter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   csb_lo = 0;
  int   rsp_cnt = 0;
  logic [32:0] exp_q [$];
  logic [31:0] sram [512];
  logic        csb_r, web_r;
  logic [3:0]  wm_r;
  logic [8:0]  a_r;
  logic [31:0] d_r;
  logic        is_wr_s;

  always #5 clk = ~clk;

  sram_port0_req_adapter_if bus ();

  sram_port0_req_adapter #(.RSP_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef SRAM_ADAPTER_WR_ACK_EN
  assign is_wr_s = bus.rsp_is_wr;
`else
  assign is_wr_s = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // macro model: latch pins at posedge, act on the falling edge
  always @(posedge clk) begin
    csb_r <= bus.mem_csb;
    web_r <= bus.mem_web;
    wm_r  <= bus.mem_wmask;
    a_r   <= bus.mem_addr;
    d_r   <= bus.mem_din;
  end

  always @(negedge clk) begin
    if (!csb_r) begin
      if (!web_r) begin
        for (int b = 0; b < 4; b++)
          if (wm_r[b]) sram[a_r][8*b +: 8] <= d_r[8*b +: 8];
      end else begin
        bus.mem_dout <= sram[a_r];
      end
    end
  end

  // response collector and csb activity counter
  always @(negedge clk) begin
    if (rst_n && !bus.mem_csb) csb_lo++;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      rsp_cnt++;
      if (exp_q.size() == 0)
        chk("rsp_extra", 64'(exp_q.size()), 1);
      else
        chk("rsp", {is_wr_s, bus.rsp_rdata}, exp_q.pop_front());
    end
  end

  task automatic do_req(input logic we, input logic [3:0] be,
                        input logic [8:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, output int waits);
    logic fired;
    fired = 1'b0;
    waits = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        fired = 1'b1;
        chk("pin_csb", bus.mem_csb, 0);
        chk("pin_web", bus.mem_web, !we);
        chk("pin_wmask", bus.mem_wmask, we ? be : 4'h0);
        chk("pin_addr", bus.mem_addr, addr);
        if (we) chk("pin_din", bus.mem_din, wd);
        if (!we) exp_q.push_back({1'b0, exp});
`ifdef SRAM_ADAPTER_WR_ACK_EN
        if (we) exp_q.push_back({1'b1, 32'h0});
`endif
        break;
      end
      waits++;
    end
    chk("req_fire", fired, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_be    = '0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.rsp_valid) break;
    end
    chk("drain", 64'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  int w, wsum, c0, r0;

  initial begin
    for (int i = 0; i < 512; i++) sram[i] = '0;
    bus.mem_dout  = '0;
    bus.rsp_ready = 1'b1;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    idle();

    // reset state
    #12;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rvalid", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_csb", bus.mem_csb, 1);
    chk("rst_web", bus.mem_web, 1);
    chk("rst_wmask", bus.mem_wmask, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", bus.req_ready, 1);

    // single write then read, latency and csb pulse count
    c0 = csb_lo;
    do_req(1, 4'hF, 9'h005, 32'hDEADBEEF, 0, w);
    do_req(0, 4'h0, 9'h005, 0, 32'hDEADBEEF, w);
    idle();
    @(negedge clk);
    chk("rv_lat0", bus.rsp_valid, 0);
    @(negedge clk);
    chk("rv_lat1", bus.rsp_valid, 1);
    @(posedge clk); #1;
    wait_drain();
    chk("csb_pulses", 64'(csb_lo - c0), 2);

    // byte masks, including an empty mask
    do_req(1, 4'hF, 9'h010, 32'h11223344, 0, w);
    do_req(1, 4'b0101, 9'h010, 32'hAABBCCDD, 0, w);
    do_req(0, 4'h0, 9'h010, 0, 32'h11BB33DD, w);
    do_req(1, 4'h0, 9'h010, 32'hFFFFFFFF, 0, w);
    do_req(0, 4'h0, 9'h010, 0, 32'h11BB33DD, w);
    idle();
    wait_drain();

    // back-to-back reads at full rate
    for (int i = 0; i < 16; i++)
      do_req(1, 4'hF, 9'(i), 32'hC0DE0000 | i, 0, w);
    idle();
    wait_drain();
    c0 = csb_lo;
    r0 = rsp_cnt;
    wsum = 0;
    for (int i = 0; i < 16; i++) begin
      do_req(0, 4'h0, 9'(i), 0, 32'hC0DE0000 | i, w);
      wsum += w;
    end
    idle();
    wait_drain();
    chk("b2b_stalls", 64'(wsum), 0);
    chk("b2b_csb", 64'(csb_lo - c0), 16);
    chk("b2b_rsps", 64'(rsp_cnt - r0), 16);

    // backpressure: four credits, then stall until drained
    bus.rsp_ready = 1'b0;
    wsum = 0;
    for (int i = 0; i < 4; i++) begin
      do_req(0, 4'h0, 9'(i), 0, 32'hC0DE0000 | i, w);
      wsum += w;
    end
    chk("bp_first4_stalls", 64'(wsum), 0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 9'h004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready_low", bus.req_ready, 0);
    end
    chk("bp_no_rsp", 64'(rsp_cnt - r0), 16);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    do_req(0, 4'h0, 9'h004, 0, 32'hC0DE0004, w);
    do_req(0, 4'h0, 9'h005, 0, 32'hC0DE0005, w);
    idle();
    wait_drain();
    chk("bp_rsps", 64'(rsp_cnt - r0), 22);

    // reset with two queued and one in flight
    bus.rsp_ready = 1'b0;
    do_req(0, 4'h0, 9'h000, 0, 32'hC0DE0000, w);
    do_req(0, 4'h0, 9'h001, 0, 32'hC0DE0001, w);
    do_req(0, 4'h0, 9'h002, 0, 32'hC0DE0002, w);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", bus.rsp_valid, 0);
    chk("mid_rst_csb", bus.mem_csb, 1);
    chk("mid_rst_ready", bus.req_ready, 0);
    exp_q.delete();
    idle();
    r0 = rsp_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_ready", bus.req_ready, 1);
    chk("post_rst_rvalid", bus.rsp_valid, 0);
    chk("post_rst_rsps", 64'(rsp_cnt - r0), 0);

`ifdef SRAM_ADAPTER_WR_ACK_EN
    // write ack followed by the read of the same word
    r0 = rsp_cnt;
    do_req(1, 4'hF, 9'h020, 32'h5A5A1234, 0, w);
    do_req(0, 4'h0, 9'h020, 0, 32'h5A5A1234, w);
    idle();
    wait_drain();
    chk("ack_rsps", 64'(rsp_cnt - r0), 2);
`endif

    chk("exp_left", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
